// File: rtl/layer_int_arbiter_if.sv
// Handshake bundle between the layer interrupt arbiter, the detector layers
// and the SPI readout engine.
interface layer_int_arbiter_if #(
  parameter int NLAYERS = 20,
  parameter int LW      = $clog2(NLAYERS)
);
  logic [NLAYERS-1:0] layer_interruptn;
  logic               enable;
  logic [NLAYERS-1:0] layer_hold;
  logic               grant_valid;
  logic [LW-1:0]      grant_layer;
  logic               grant_ready;
  logic               readout_done;
  logic [NLAYERS-1:0] pending;
  logic               busy;
  logic               timeout_err;
  logic [7:0]         spurious_cnt;

  modport master (
    input  layer_interruptn, enable, grant_ready, readout_done,
    output layer_hold, grant_valid, grant_layer, pending, busy,
           timeout_err, spurious_cnt
  );

  modport slave (
    output layer_interruptn, enable, grant_ready, readout_done,
    input  layer_hold, grant_valid, grant_layer, pending, busy,
           timeout_err, spurious_cnt
  );
endinterface

// File: rtl/layer_int_arbiter.sv
// Round-robin arbiter: synchronizes active-low layer interrupts, holds one
// layer at a time and hands it to the SPI readout engine.
module layer_int_arbiter #(
  parameter int NLAYERS     = 20,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_SETTLE = 4,
  parameter int TIMEOUT     = 1024,
  parameter int LW          = $clog2(NLAYERS)
) (
  input  logic                  sysclk,
  input  logic                  rst,
  layer_int_arbiter_if.master   bus
);

  typedef enum logic [2:0] {IDLE, HOLD, GRANT, READOUT, RELEASE} state_t;

  localparam int CMAX = (TIMEOUT > HOLD_SETTLE) ? TIMEOUT : HOLD_SETTLE;
  localparam int CW   = $clog2(CMAX) + 1;

  state_t             state_q, state_d;
  logic [NLAYERS-1:0] sync_q [SYNC_STAGES];
  logic [NLAYERS-1:0] pending_w;
  logic [CW-1:0]      cnt_q;
  logic [LW-1:0]      grant_q;
  logic [LW-1:0]      last_q;
  logic               sel_q;
  logic [7:0]         spur_q;
  logic               sel_found;
  logic [LW-1:0]      sel_idx;
  logic               sel_take;
  int                 cand;
  logic [LW-1:0]      cand_idx;

  assign pending_w = sync_q[SYNC_STAGES-1];
  assign sel_take  = (state_q == IDLE) && !sel_q && bus.enable && sel_found;

  // Round-robin search starting just above the last accepted grant.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NLAYERS; i++) begin
      cand = int'(last_q) + 1 + i;
      if (cand >= NLAYERS) cand = cand - NLAYERS;
      cand_idx = LW'(cand);
      if (!sel_found && pending_w[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_q) state_d = HOLD;
      HOLD: begin
        if (!pending_w[grant_q])                  state_d = RELEASE;
        else if (cnt_q == CW'(HOLD_SETTLE - 1))   state_d = GRANT;
      end
      GRANT:   if (bus.grant_ready) state_d = READOUT;
      READOUT: if (bus.readout_done || cnt_q == CW'(TIMEOUT - 1)) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The selection is registered for one IDLE cycle before HOLD, so grant_layer
  // is settled before any hold line is driven.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= LW'(NLAYERS - 1);
      sel_q   <= 1'b0;
      spur_q  <= '0;
    end else begin
      sync_q[0] <= ~bus.layer_interruptn;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sel_q <= sel_take;
      if (sel_take) grant_q <= sel_idx;
      if (state_q == GRANT && bus.grant_ready) last_q <= grant_q;
      if (state_q == HOLD && !pending_w[grant_q] && spur_q != 8'hFF)
        spur_q <= spur_q + 8'd1;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == HOLD || state_q == READOUT)
        cnt_q <= cnt_q + CW'(1);
    end
  end

  // A readout_done arriving in the final timeout cycle wins over the timeout.
  always_comb begin
    bus.layer_hold  = '0;
    bus.grant_valid = 1'b0;
    bus.busy        = (state_q != IDLE);
    bus.timeout_err = 1'b0;
    case (state_q)
      HOLD:    bus.layer_hold[grant_q] = 1'b1;
      GRANT: begin
        bus.layer_hold[grant_q] = 1'b1;
        bus.grant_valid         = 1'b1;
      end
      READOUT: begin
        bus.layer_hold[grant_q] = 1'b1;
        bus.timeout_err = !bus.readout_done && (cnt_q == CW'(TIMEOUT - 1));
      end
      default: ;
    endcase
  end

  assign bus.grant_layer  = grant_q;
  assign bus.pending      = pending_w;
  assign bus.spurious_cnt = spur_q;

endmodule

// File: tb/tb_layer_int_arbiter.sv
// Self-checking bench for layer_int_arbiter: directed vectors, corner-case
// sequences and randomized traffic against a round-robin reference model.
module tb_layer_int_arbiter;

  localparam int NL = 20;
  localparam int SS = 2;
  localparam int HS = 4;
  localparam int TO = 1024;
  localparam int LW = $clog2(NL);

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 sysclk = ~sysclk;

  layer_int_arbiter_if #(.NLAYERS(NL), .LW(LW)) bus ();

  layer_int_arbiter #(
    .NLAYERS(NL), .SYNC_STAGES(SS), .HOLD_SETTLE(HS), .TIMEOUT(TO), .LW(LW)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [NL-1:0]        low_mask;
    logic [3:0][LW-1:0]   exp_grant;
  } rr_vec_t;

  rr_vec_t vecs [5];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NL-1:0] low_mask, input logic en);
    bus.layer_interruptn = ~low_mask;
    bus.enable           = en;
  endtask

  task automatic doReset();
    rst              = 1'b1;
    bus.grant_ready  = 1'b0;
    bus.readout_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [NL-1:0] onehot(input int idx);
    logic [NL-1:0] v;
    v = '0;
    if (idx >= 0 && idx < NL) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic rr_vec_t mkVec(input logic [NL-1:0] m, input int a, input int b,
                                    input int c, input int d);
    rr_vec_t r;
    r.low_mask     = m;
    r.exp_grant[0] = LW'(a);
    r.exp_grant[1] = LW'(b);
    r.exp_grant[2] = LW'(c);
    r.exp_grant[3] = LW'(d);
    return r;
  endfunction

  // Reference: list the requesting layers in ascending order, take the first
  // one above the previous grant, otherwise wrap to the lowest.
  function automatic int modelPick(input logic [NL-1:0] mask, input int last);
    int q[$];
    int res;
    res = -1;
    for (int i = 0; i < NL; i++) if (mask[i]) q.push_back(i);
    for (int k = 0; k < q.size(); k++) if (res < 0 && q[k] > last) res = q[k];
    if (res < 0 && q.size() > 0) res = q[0];
    return res;
  endfunction

  function automatic logic [NL-1:0] randMask();
    logic [NL-1:0] m;
    m = NL'($urandom) & NL'($urandom);
    if (m == '0) m = onehot(int'($urandom_range(0, NL - 1)));
    return m;
  endfunction

  task automatic waitGrant(input int limit, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      if (bus.grant_valid) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic waitHold(input int idx, input int limit, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      if (bus.layer_hold[idx]) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic runTransaction(input int exp);
    bit ok;
    waitGrant(60, ok);
    checkOutput("rr_grant_seen", ok, 1);
    if (ok) begin
      checkOutput("rr_grant_layer", bus.grant_layer, exp);
      checkOutput("rr_hold", bus.layer_hold, onehot(exp));
      bus.grant_ready = 1'b1;
      tick();
      bus.grant_ready = 1'b0;
      tick();
      bus.readout_done = 1'b1;
      tick();
      bus.readout_done = 1'b0;
      checkOutput("rr_release_hold", bus.layer_hold, 0);
    end
  endtask

  // Drive a layer to the start of READOUT; caller is left in READOUT cycle 1.
  task automatic enterReadout(input int idx, output bit ok);
    applyStimulus('0, 1'b0);
    doReset();
    applyStimulus(onehot(idx), 1'b1);
    waitGrant(60, ok);
    checkOutput("ro_grant_seen", ok, 1);
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
  endtask

  initial begin
    bit            ok;
    bit            seen;
    int            last;
    int            exp;
    logic [NL-1:0] mask;

    bus.layer_interruptn = '1;
    bus.enable           = 1'b0;
    bus.grant_ready      = 1'b0;
    bus.readout_done     = 1'b0;

    vecs[0] = mkVec(onehot(0) | onehot(5) | onehot(19), 0, 5, 19, 0);
    vecs[1] = mkVec(onehot(7), 7, 7, 7, 7);
    vecs[2] = mkVec(onehot(3) | onehot(10), 3, 10, 3, 10);
    vecs[3] = mkVec(onehot(1) | onehot(2) | onehot(18), 1, 2, 18, 1);
    vecs[4] = mkVec(onehot(19), 19, 19, 19, 19);

    applyStimulus(onehot(7), 1'b1);
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_pending", bus.pending, 0);
    checkOutput("rst_hold", bus.layer_hold, 0);
    checkOutput("rst_grant_valid", bus.grant_valid, 0);
    checkOutput("rst_grant_layer", bus.grant_layer, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_timeout", bus.timeout_err, 0);
    checkOutput("rst_spurious", bus.spurious_cnt, 0);

    applyStimulus('0, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(onehot(7), 1'b1);
    for (int k = 1; k <= SS + 2 + HS; k++) begin
      tick();
      if (k == SS + 1)      checkOutput("lat_hold_early", bus.layer_hold, 0);
      if (k == SS + 2)      checkOutput("lat_hold", bus.layer_hold, onehot(7));
      if (k == SS + 1 + HS) checkOutput("lat_gv_early", bus.grant_valid, 0);
      if (k == SS + 2 + HS) begin
        checkOutput("lat_gv", bus.grant_valid, 1);
        checkOutput("lat_grant_layer", bus.grant_layer, 7);
      end
    end
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
    checkOutput("single_readout_busy", bus.busy, 1);
    checkOutput("single_readout_hold", bus.layer_hold, onehot(7));
    bus.readout_done = 1'b1;
    tick();
    bus.readout_done = 1'b0;
    checkOutput("single_release_hold", bus.layer_hold, 0);
    checkOutput("single_release_busy", bus.busy, 1);
    applyStimulus('0, 1'b1);
    tick();
    checkOutput("single_idle_busy", bus.busy, 0);

    for (int v = 0; v < 5; v++) begin
      applyStimulus('0, 1'b0);
      doReset();
      applyStimulus(vecs[v].low_mask, 1'b1);
      for (int t = 0; t < 4; t++) runTransaction(int'(vecs[v].exp_grant[t]));
    end

    applyStimulus('0, 1'b0);
    doReset();
    applyStimulus(onehot(3), 1'b1);
    waitHold(3, 20, ok);
    checkOutput("spur_hold_seen", ok, 1);
    applyStimulus('0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.grant_valid) seen = 1'b1;
    end
    checkOutput("spur_no_grant", seen, 0);
    checkOutput("spur_count", bus.spurious_cnt, 1);
    checkOutput("spur_busy", bus.busy, 0);
    checkOutput("spur_hold", bus.layer_hold, 0);

    enterReadout(2, ok);
    seen = 1'b0;
    for (int c = 1; c < TO; c++) begin
      if (bus.timeout_err) seen = 1'b1;
      tick();
    end
    checkOutput("to_early_pulse", seen, 0);
    checkOutput("to_pulse", bus.timeout_err, 1);
    checkOutput("to_hold_still", bus.layer_hold, onehot(2));
    tick();
    checkOutput("to_pulse_end", bus.timeout_err, 0);
    checkOutput("to_release_hold", bus.layer_hold, 0);
    checkOutput("to_release_busy", bus.busy, 1);
    applyStimulus('0, 1'b1);
    tick();
    checkOutput("to_idle_busy", bus.busy, 0);

    enterReadout(2, ok);
    for (int c = 1; c < TO; c++) tick();
    bus.readout_done = 1'b1;
    #1;
    checkOutput("coincide_no_timeout", bus.timeout_err, 0);
    tick();
    bus.readout_done = 1'b0;
    checkOutput("coincide_release_hold", bus.layer_hold, 0);
    checkOutput("coincide_release_busy", bus.busy, 1);

    applyStimulus('0, 1'b0);
    doReset();
    applyStimulus(onehot(4), 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.busy) seen = 1'b1;
    end
    checkOutput("en_gate_busy", seen, 0);
    checkOutput("en_gate_pending", bus.pending, onehot(4));
    applyStimulus(onehot(4), 1'b1);
    waitHold(4, 20, ok);
    checkOutput("en_hold_seen", ok, 1);
    applyStimulus(onehot(4), 1'b0);
    waitGrant(20, ok);
    checkOutput("en_drop_grant_seen", ok, 1);
    checkOutput("en_drop_grant_layer", bus.grant_layer, 4);
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_hold", bus.layer_hold, 0);
    checkOutput("midrst_grant_valid", bus.grant_valid, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_grant_layer", bus.grant_layer, 0);
    checkOutput("midrst_pending", bus.pending, 0);
    checkOutput("midrst_timeout", bus.timeout_err, 0);
    rst = 1'b0;

    applyStimulus('0, 1'b0);
    doReset();
    mask = randMask();
    applyStimulus(mask, 1'b1);
    last = NL - 1;
    for (int n = 0; n < 40; n++) begin
      waitGrant(80, ok);
      checkOutput("rand_grant_seen", ok, 1);
      if (!ok) break;
      exp = modelPick(mask, last);
      checkOutput("rand_grant_layer", bus.grant_layer, exp);
      checkOutput("rand_hold", bus.layer_hold, onehot(exp));
      seen = 1'b1;
      repeat ($urandom_range(0, 3)) begin
        tick();
        if (!bus.grant_valid || bus.grant_layer != LW'(exp)) seen = 1'b0;
      end
      checkOutput("rand_grant_stable", seen, 1);
      bus.grant_ready = 1'b1;
      tick();
      bus.grant_ready = 1'b0;
      last = exp;
      mask = randMask();
      applyStimulus(mask, 1'b1);
      repeat ($urandom_range(3, 8)) tick();
      bus.readout_done = 1'b1;
      tick();
      bus.readout_done = 1'b0;
      checkOutput("rand_release_hold", bus.layer_hold, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
